// File: rtl/ahb_master_req.sv
// AHB requester port: queues local transfer commands, requests the bus and issues
// single non-pipelined transfers paced by hready, releasing the bus after MAX_HOLD transfers.
module ahb_master_req #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_HOLD   = 4
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              hreq,
  input  logic              hgrant,
  input  logic              hready,
  output logic [1:0]        htrans,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_DATA,
    S_GAP
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t              mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              dp_write_q, dp_write_d;
  logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  cmd_t head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign push       = cmd_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q];
  assign cmd_ready  = !fifo_full;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;

  // NOTE: the storage array has no reset; count_q alone decides which entries are live.
  always_ff @(posedge hclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_rdata_d = '0;
    pop         = 1'b0;
    hreq        = 1'b0;
    htrans      = HTRANS_IDLE;
    haddr       = '0;
    hwrite      = 1'b0;
    hwdata      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_REQ;
      end
      S_REQ: begin
        hreq = 1'b1;
        if (hgrant && hready) state_d = S_ADDR;
      end
      S_ADDR: begin
        hreq   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = head.addr;
        hwrite = head.write;
        // A lost grant abandons this address phase; the command stays at the head.
        if (!hgrant) begin
          state_d = S_REQ;
        end else if (hready) begin
          pop        = 1'b1;
          hold_d     = hold_q + HOLD_W'(1);
          dp_write_d = head.write;
          dp_wdata_d = head.write ? head.wdata : '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        hreq   = 1'b1;
        hwdata = dp_wdata_q;
        if (hready) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = dp_write_q;
          rsp_rdata_d = dp_write_q ? '0 : hrdata;
          if (fifo_empty) begin
            state_d = S_IDLE;
            hold_d  = '0;
          end else if (hold_q == HOLD_W'(MAX_HOLD)) begin
            state_d = S_GAP;
            hold_d  = '0;
          end else begin
            state_d = hgrant ? S_ADDR : S_REQ;
          end
        end
      end
      S_GAP: begin
        state_d = fifo_empty ? S_IDLE : S_REQ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      hold_q      <= '0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_req.sv
// Bench for ahb_master_req: a queue-based bus model checked every cycle, directed
// scenarios with literal expectations, then randomized grant/ready/command traffic.
module tb_ahb_master_req;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_HOLD   = 4;

  logic              hclk      = 1'b0;
  logic              hreset    = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr  = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              hgrant    = 1'b0;
  logic              hready    = 1'b1;
  logic [DATA_W-1:0] hrdata    = '0;
  logic              cmd_ready;
  logic              hreq;
  logic [1:0]        htrans;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;

  ahb_master_req #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .hreq(hreq), .hgrant(hgrant), .hready(hready),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata)
  );

  always #5 hclk = ~hclk;

  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event never arrived within its cycle budget (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural model: command queue + bus phase ----------------
  typedef struct {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } cmd_s;

  typedef enum {P_IDLE, P_WANT, P_ADDR, P_DATA, P_GAP} phase_e;

  cmd_s              m_q[$];
  cmd_s              m_cur;
  phase_e            m_ph     = P_IDLE;
  int                m_tenure = 0;
  logic              m_rsp_v  = 1'b0;
  logic              m_rsp_w  = 1'b0;
  logic [DATA_W-1:0] m_rsp_d  = '0;

  always @(posedge hclk) begin
    cmd_s   c;
    bit     take;
    phase_e nx;
    if (hreset) begin
      m_q.delete();
      m_ph     = P_IDLE;
      m_tenure = 0;
      m_rsp_v  = 1'b0;
      m_rsp_w  = 1'b0;
      m_rsp_d  = '0;
    end else begin
      take    = cmd_valid && (m_q.size() < FIFO_DEPTH);
      c.w     = cmd_write;
      c.a     = cmd_addr;
      c.d     = cmd_wdata;
      m_rsp_v = 1'b0;
      m_rsp_w = 1'b0;
      m_rsp_d = '0;
      nx      = m_ph;
      case (m_ph)
        P_IDLE: if (m_q.size() > 0) nx = P_WANT;
        P_WANT: if (hgrant && hready) nx = P_ADDR;
        P_ADDR: begin
          if (!hgrant) nx = P_WANT;
          else if (hready) begin
            m_cur = m_q.pop_front();
            m_tenure++;
            nx = P_DATA;
          end
        end
        P_DATA: begin
          if (hready) begin
            m_rsp_v = 1'b1;
            m_rsp_w = m_cur.w;
            m_rsp_d = m_cur.w ? '0 : hrdata;
            if (m_q.size() == 0) begin
              nx = P_IDLE;
              m_tenure = 0;
            end else if (m_tenure == MAX_HOLD) begin
              nx = P_GAP;
              m_tenure = 0;
            end else begin
              nx = hgrant ? P_ADDR : P_WANT;
            end
          end
        end
        P_GAP: nx = (m_q.size() > 0) ? P_WANT : P_IDLE;
        default: nx = P_IDLE;
      endcase
      if (take) m_q.push_back(c);
      m_ph = nx;
    end
  end

  always @(negedge hclk) begin
    logic [ADDR_W-1:0] e_addr;
    logic              e_wr;
    logic [DATA_W-1:0] e_wd;
    if (chk_en) begin
      e_addr = '0;
      e_wr   = 1'b0;
      e_wd   = '0;
      if (m_ph == P_ADDR && m_q.size() > 0) begin
        e_addr = m_q[0].a;
        e_wr   = m_q[0].w;
      end
      if (m_ph == P_DATA && m_cur.w) e_wd = m_cur.d;
      check("m_cmd_ready", cmd_ready, m_q.size() < FIFO_DEPTH);
      check("m_hreq", hreq, m_ph inside {P_WANT, P_ADDR, P_DATA});
      check("m_htrans", htrans, (m_ph == P_ADDR) ? 2'b10 : 2'b00);
      check("m_haddr", haddr, e_addr);
      check("m_hwrite", hwrite, e_wr);
      check("m_hwdata", hwdata, e_wd);
      check("m_rsp_valid", rsp_valid, m_rsp_v);
      check("m_rsp_write", rsp_write, m_rsp_w);
      check("m_rsp_rdata", rsp_rdata, m_rsp_d);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic sample_at(input int c);
    @(negedge hclk);
    while (cyc < c) @(negedge hclk);
  endtask

  task automatic do_reset();
    hreset    = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) next_cycle();
    hreset = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic push(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit acc;
    bit done;
    done      = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int g = 0; g < 100 && !done; g++) begin
      @(negedge hclk);
      acc = cmd_ready;
      next_cycle();
      if (acc) done = 1'b1;
    end
    cmd_valid = 1'b0;
    if (!done) timeout("push_accept");
  endtask

  task automatic wait_addr(input string tag, output int x);
    x = -1;
    for (int g = 0; g < 100 && x < 0; g++) begin
      @(negedge hclk);
      if (htrans == 2'b10) x = cyc;
    end
    if (x < 0) timeout(tag);
  endtask

  task automatic count_rsps(input int want, input int budget, output int got);
    got = 0;
    for (int g = 0; g < budget && got < want; g++) begin
      @(negedge hclk);
      if (rsp_valid) got++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int x;
    int got;
    int rc;
    int lows;
    int burst;
    bit seen_hi;
    bit ready_low_ok;

    do_reset();
    check("reset_hreq", hreq, 1'b0);
    check("reset_cmd_ready", cmd_ready, 1'b1);

    // 1: single read, uncontested latency
    hgrant = 1'b1;
    hready = 1'b1;
    hrdata = 32'hDEADBEEF;
    next_cycle();
    n0 = cyc;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h100;
    cmd_wdata = 32'h0;
    next_cycle();
    cmd_valid = 1'b0;
    sample_at(n0 + 1); check("t1_hreq_n1", hreq, 1'b0);
    sample_at(n0 + 2); check("t1_hreq_n2", hreq, 1'b1); check("t1_htrans_n2", htrans, 2'b00);
    sample_at(n0 + 3); check("t1_htrans_n3", htrans, 2'b10);
    check("t1_haddr_n3", haddr, 32'h100); check("t1_hwrite_n3", hwrite, 1'b0);
    sample_at(n0 + 4); check("t1_htrans_n4", htrans, 2'b00); check("t1_rsp_n4", rsp_valid, 1'b0);
    sample_at(n0 + 5); check("t1_rsp_valid_n5", rsp_valid, 1'b1);
    check("t1_rsp_rdata_n5", rsp_rdata, 32'hDEADBEEF); check("t1_hreq_n5", hreq, 1'b0);

    // 2: write waits five cycles for the grant
    hgrant = 1'b0;
    hrdata = 32'h12345678;
    next_cycle();
    n0 = cyc;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h200;
    cmd_wdata = 32'hCAFE0001;
    next_cycle();
    cmd_valid = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      sample_at(n0 + k);
      check("t2_hreq_wait", hreq, 1'b1);
      check("t2_htrans_wait", htrans, 2'b00);
    end
    hgrant = 1'b1;
    sample_at(n0 + 7); check("t2_htrans_addr", htrans, 2'b10);
    check("t2_haddr", haddr, 32'h200); check("t2_hwrite", hwrite, 1'b1);
    sample_at(n0 + 8); check("t2_hwdata", hwdata, 32'hCAFE0001);
    sample_at(n0 + 9); check("t2_rsp_valid", rsp_valid, 1'b1);
    check("t2_rsp_write", rsp_write, 1'b1); check("t2_rsp_rdata", rsp_rdata, 32'h0);

    // 3: six commands with the grant held -> 4, one-cycle release, 2
    hgrant = 1'b1;
    hready = 1'b1;
    next_cycle();
    got = 0; lows = 0; burst = 0; seen_hi = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) push(k[0], 32'h300 + k * 4, $urandom);
      end
      begin
        for (int g = 0; g < 200 && got < 6; g++) begin
          @(negedge hclk);
          if (rsp_valid) got++;
          if (got < 6) begin
            if (hreq) seen_hi = 1'b1;
            else if (seen_hi) lows++;
            if (htrans == 2'b10 && lows == 0) burst++;
          end
        end
      end
    join
    check("t3_rsp_count", got, 6);
    check("t3_release_cycles", lows, 1);
    check("t3_first_tenure", burst, MAX_HOLD);

    // 4: stalled read data phase with the grant withdrawn
    hgrant = 1'b1;
    hready = 1'b1;
    next_cycle();
    push(1'b0, 32'h400, 32'h0);
    push(1'b0, 32'h404, 32'h0);
    wait_addr("t4_addr", x);
    next_cycle();
    hready = 1'b0;
    hgrant = 1'b0;
    rc = 0;
    sample_at(x + 1); rc += int'(rsp_valid);
    check("t4_data_htrans", htrans, 2'b00); check("t4_data_hreq", hreq, 1'b1);
    next_cycle(); sample_at(x + 2); rc += int'(rsp_valid);
    next_cycle(); sample_at(x + 3); rc += int'(rsp_valid);
    next_cycle();
    hready = 1'b1;
    hrdata = 32'hA5A50004;
    sample_at(x + 4); rc += int'(rsp_valid); check("t4_still_data_hreq", hreq, 1'b1);
    sample_at(x + 5); rc += int'(rsp_valid);
    check("t4_rsp_valid", rsp_valid, 1'b1); check("t4_rsp_rdata", rsp_rdata, 32'hA5A50004);
    check("t4_back_to_req_hreq", hreq, 1'b1); check("t4_back_to_req_htrans", htrans, 2'b00);
    sample_at(x + 6); rc += int'(rsp_valid); check("t4_req_htrans", htrans, 2'b00);
    check("t4_single_rsp", rc, 1);
    hgrant = 1'b1;
    count_rsps(1, 50, got);
    check("t4_second_rsp", got, 1);

    // 5: FIFO fills while ungranted; fifth push lands after the first pop
    hgrant = 1'b0;
    hready = 1'b1;
    next_cycle();
    for (int k = 0; k < 4; k++) push(1'b1, 32'h500 + k * 4, 32'h5000 + k);
    @(negedge hclk);
    check("t5_full_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h510;
    hgrant    = 1'b1;
    ready_low_ok = 1'b1;
    x = -1;
    for (int g = 0; g < 50 && x < 0; g++) begin
      @(negedge hclk);
      if (cmd_ready) ready_low_ok = 1'b0;
      if (htrans == 2'b10) x = cyc;
    end
    if (x < 0) timeout("t5_first_addr");
    check("t5_ready_low_until_pop", ready_low_ok, 1'b1);
    sample_at(x + 1);
    check("t5_ready_after_pop", cmd_ready, 1'b1);
    next_cycle();
    cmd_valid = 1'b0;
    count_rsps(5, 200, got);
    check("t5_rsp_count", got, 5);

    // 6: reset during a data phase with two commands queued
    hgrant = 1'b0;
    hready = 1'b1;
    next_cycle();
    for (int k = 0; k < 3; k++) push(1'b1, 32'h600 + k * 4, 32'h6000 + k);
    hgrant = 1'b1;
    wait_addr("t6_addr", x);
    next_cycle();
    hready = 1'b0;
    hreset = 1'b1;
    sample_at(x + 1); check("t6_in_data", htrans, 2'b00);
    next_cycle();
    hreset = 1'b0;
    hready = 1'b1;
    sample_at(x + 2);
    check("t6_hreq", hreq, 1'b0);
    check("t6_htrans", htrans, 2'b00);
    check("t6_haddr", haddr, 32'h0);
    check("t6_hwrite", hwrite, 1'b0);
    check("t6_hwdata", hwdata, 32'h0);
    check("t6_rsp_valid", rsp_valid, 1'b0);
    check("t6_rsp_write", rsp_write, 1'b0);
    check("t6_rsp_rdata", rsp_rdata, 32'h0);
    check("t6_cmd_ready", cmd_ready, 1'b1);
    rc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge hclk);
      rc += int'(hreq) + int'(rsp_valid);
    end
    check("t6_quiet_after_reset", rc, 0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      cmd_valid = ($urandom_range(0, 99) < 40);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      hgrant    = ($urandom_range(0, 99) < 70);
      hready    = ($urandom_range(0, 99) < 75);
      hrdata    = $urandom;
      hreset    = ($urandom_range(0, 999) == 0);
    end
    next_cycle();
    cmd_valid = 1'b0;
    hreset    = 1'b0;
    hgrant    = 1'b1;
    hready    = 1'b1;
    repeat (60) next_cycle();
    @(negedge hclk);
    check("drain_hreq", hreq, 1'b0);
    check("drain_cmd_ready", cmd_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
